multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPCODE_W, default 7: opcode field width.
REQ-002 SHALL have parameter ALUOP_W, default 2: ALUOp width; values 00 add, 01 compare, 10 funct-decoded, 11 pass-B (LUI).
REQ-003 SHALL have parameter MAX_WAIT, default 15: maximum mem_ready wait cycles before a timeout trap; minimum 1.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port opcode, input, OPCODE_W: instruction opcode, sampled only in DECODE.
REQ-007 SHALL have port mem_ready, input, 1: memory completion strobe for the current FETCH/MEM access.
REQ-008 SHALL have output ports pc_wr and ir_wr, 1 bit each: PC update strobe and instruction-register load strobe.
REQ-009 SHALL have output ports branch, mem_rd, memtoReg, mem_wr, ALUSrc, reg_wr, 1 bit each: datapath controls with single-cycle-datapath meaning.
REQ-010 SHALL have output ALUOp, ALUOP_W: ALU operation class.
REQ-011 SHALL have output illegal, 1: sticky trap flag.
REQ-012 SHALL have output state, 3: current FSM state encoding.

Function
REQ-013 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; all outputs SHALL be decoded from the state and the opcode class latched in DECODE.
REQ-014 FETCH: mem_rd=1. On mem_ready=1: ir_wr=1, pc_wr=1, go to DECODE; otherwise stay.
REQ-015 DECODE: latch the opcode class (R 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011, I-ALU 0010011); unknown opcode goes to TRAP, otherwise to EXEC.
REQ-016 EXEC controls: R: ALUSrc=0, ALUOp=10. I-ALU: ALUSrc=1, ALUOp=10. LOAD/STORE: ALUSrc=1, ALUOp=00. BRANCH: branch=1, ALUOp=01, ALUSrc=0.
REQ-017 EXEC transitions: R and I-ALU go to WB; LOAD and STORE go to MEM; BRANCH goes to FETCH.
REQ-018 MEM: LOAD drives mem_rd=1; STORE drives mem_wr=1. On mem_ready: LOAD goes to WB, STORE goes to FETCH.
REQ-019 WB: reg_wr=1 for one cycle; memtoReg=1 only for LOAD; then go to FETCH.
REQ-020 With zero-wait memory, instruction latency SHALL be R/I-ALU 4, LOAD 5, STORE 4, BRANCH 3 cycles.
REQ-021 A wait counter (width clog2(MAX_WAIT+1)) SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0.
REQ-022 Reaching MAX_WAIT with mem_ready=0 SHALL move the FSM to TRAP; mem_ready in that same cycle wins (normal transition).
REQ-023 In TRAP, illegal=1 and all other controls are 0; the FSM SHALL leave TRAP only on rst.
REQ-024 mem_ready outside FETCH/MEM SHALL be ignored; mem_rd and mem_wr SHALL never both be 1.

Reset
REQ-025 With rst=1 at a clock edge, the state SHALL become FETCH, the wait counter 0, the latched class R, and illegal 0.
REQ-026 While rst=1, all outputs except state SHALL be forced to 0; a mid-instruction reset abandons the instruction without emitting any reg_wr or mem_wr.

Configuration
REQ-027 Macro MULTICYCLE_CONTROL_JUMP_EN, when defined, SHALL add the JAL (1101111), JALR (1100111) and LUI (0110111) classes.
REQ-028 With the macro defined: JAL/JALR EXEC drives pc_wr=1, ALUSrc=1, ALUOp=00, then WB (reg_wr=1) then FETCH; LUI EXEC drives ALUOp=11, ALUSrc=1, then WB.
REQ-029 Without the macro, those three opcodes SHALL be illegal and go to TRAP.

Verification
REQ-030 Reset, then opcode 0110011 with mem_ready tied to 1 -> state sequence 0,1,2,4,0; reg_wr=1 only in state 4; ALUOp=10 in EXEC.
REQ-031 Load 0000011 with mem_ready low for 3 cycles in MEM -> MEM held 4 cycles with mem_rd=1; WB shows memtoReg=1 and reg_wr=1.
REQ-032 Store 0100011 then branch 1100011 -> mem_wr=1 in MEM with reg_wr=0 throughout; branch=1 and ALUOp=01 in EXEC; 3-cycle return to FETCH.
REQ-033 opcode 1111111 in DECODE -> TRAP, illegal=1 held for 10 cycles; rst pulse -> FETCH with illegal=0.
REQ-034 mem_ready held 0 in FETCH with MAX_WAIT=15 -> TRAP after 15 waiting cycles; variant asserting mem_ready on the 15th cycle -> DECODE.
REQ-035 rst asserted in MEM during a store -> next cycle FETCH, with no further mem_wr pulse.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control -- Moore control FSM for a multicycle RISC-V style datapath.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset; forces all outputs except state to 0
//   opcode     instruction opcode, sampled only in DECODE
//   mem_ready  memory completion strobe for the current FETCH/MEM access
//   pc_wr, ir_wr                 PC update / instruction-register load strobes
//   branch, mem_rd, memtoReg, mem_wr, ALUSrc, reg_wr, ALUOp
//                                datapath controls
//   illegal    trap flag, held while in TRAP until rst
//   state      current FSM state encoding
//
// Optional feature: define MULTICYCLE_CONTROL_JUMP_EN to add JAL, JALR and LUI.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | read instruction, wait for mem_ready, then load IR and PC
// DECODE | classify opcode and latch the class
// EXEC   | ALU operation for the latched class
// MEM    | data access for LOAD/STORE, wait for mem_ready
// WB     | register-file write
// TRAP   | illegal opcode or memory timeout; left only through rst
module multicycle_control #(
   parameter int OPCODE_W = 7,
   parameter int ALUOP_W  = 2,
   parameter int MAX_WAIT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_wr,
   output logic                ir_wr,
   output logic                branch,
   output logic                mem_rd,
   output logic                memtoReg,
   output logic                mem_wr,
   output logic                ALUSrc,
   output logic                reg_wr,
   output logic [ALUOP_W-1:0]  ALUOp,
   output logic                illegal,
   output logic [2:0]          state
);

   localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd7;

   localparam logic [2:0] C_R      = 3'd0;
   localparam logic [2:0] C_LOAD   = 3'd1;
   localparam logic [2:0] C_STORE  = 3'd2;
   localparam logic [2:0] C_BRANCH = 3'd3;
   localparam logic [2:0] C_IALU   = 3'd4;

   localparam logic [OPCODE_W-1:0] OP_R      = OPCODE_W'(7'b0110011);
   localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
   localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
   localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);
   localparam logic [OPCODE_W-1:0] OP_IALU   = OPCODE_W'(7'b0010011);

`ifdef MULTICYCLE_CONTROL_JUMP_EN
   localparam logic [2:0] C_JAL  = 3'd5;
   localparam logic [2:0] C_JALR = 3'd6;
   localparam logic [2:0] C_LUI  = 3'd7;

   localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(7'b1101111);
   localparam logic [OPCODE_W-1:0] OP_JALR = OPCODE_W'(7'b1100111);
   localparam logic [OPCODE_W-1:0] OP_LUI  = OPCODE_W'(7'b0110111);
`endif

   logic [2:0]       state_next;
   logic [2:0]       cls;
   logic [2:0]       cls_dec;
   logic             dec_legal;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout;

   always_comb begin
      cls_dec   = C_R;
      dec_legal = 1'b1;
      case (opcode)
         OP_R:      cls_dec = C_R;
         OP_LOAD:   cls_dec = C_LOAD;
         OP_STORE:  cls_dec = C_STORE;
         OP_BRANCH: cls_dec = C_BRANCH;
         OP_IALU:   cls_dec = C_IALU;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
         OP_JAL:    cls_dec = C_JAL;
         OP_JALR:   cls_dec = C_JALR;
         OP_LUI:    cls_dec = C_LUI;
`endif
         default:   dec_legal = 1'b0;
      endcase
   end

   // mem_ready in the last allowed cycle still completes the access.
   assign timeout = !mem_ready && (wait_cnt == CNT_W'(MAX_WAIT - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH: begin
            if (mem_ready)    state_next = S_DECODE;
            else if (timeout) state_next = S_TRAP;
         end
         S_DECODE: state_next = dec_legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            case (cls)
               C_LOAD, C_STORE: state_next = S_MEM;
               C_BRANCH:        state_next = S_FETCH;
               default:         state_next = S_WB;
            endcase
         end
         S_MEM: begin
            if (mem_ready)    state_next = (cls == C_LOAD) ? S_WB : S_FETCH;
            else if (timeout) state_next = S_TRAP;
         end
         S_WB:    state_next = S_FETCH;
         default: state_next = S_TRAP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)                   cls <= C_R;
      else if (state == S_DECODE) cls <= cls_dec;
   end

   // Any state change clears the counter, so it always starts at 0 on
   // entry to FETCH or MEM.
   always_ff @(posedge clk) begin
      if (rst)
         wait_cnt <= '0;
      else if (state_next != state)
         wait_cnt <= '0;
      else if (((state == S_FETCH) || (state == S_MEM)) && !mem_ready)
         wait_cnt <= wait_cnt + CNT_W'(1);
   end

   always_comb begin
      pc_wr    = 1'b0;
      ir_wr    = 1'b0;
      branch   = 1'b0;
      mem_rd   = 1'b0;
      memtoReg = 1'b0;
      mem_wr   = 1'b0;
      ALUSrc   = 1'b0;
      reg_wr   = 1'b0;
      ALUOp    = '0;
      illegal  = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               mem_rd = 1'b1;
               ir_wr  = mem_ready;
               pc_wr  = mem_ready;
            end
            S_EXEC: begin
               case (cls)
                  C_R:      ALUOp = ALUOP_W'(2'b10);
                  C_IALU: begin
                     ALUSrc = 1'b1;
                     ALUOp  = ALUOP_W'(2'b10);
                  end
                  C_LOAD, C_STORE: ALUSrc = 1'b1;
                  C_BRANCH: begin
                     branch = 1'b1;
                     ALUOp  = ALUOP_W'(2'b01);
                  end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
                  C_JAL, C_JALR: begin
                     pc_wr  = 1'b1;
                     ALUSrc = 1'b1;
                  end
                  C_LUI: begin
                     ALUSrc = 1'b1;
                     ALUOp  = ALUOP_W'(2'b11);
                  end
`endif
                  default: ;
               endcase
            end
            S_MEM: begin
               mem_rd = (cls == C_LOAD);
               mem_wr = (cls == C_STORE);
            end
            S_WB: begin
               reg_wr   = 1'b1;
               memtoReg = (cls == C_LOAD);
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. Instructions are issued cycle by cycle;
// each cycle the expected output vector, derived from the per-class
// instruction rules, is queued, and a negedge monitor pops and compares.
module tb_multicycle_control;

   localparam int MAXW = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mem_ready = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic       pc_wr, ir_wr, branch, mem_rd, memtoReg, mem_wr, ALUSrc, reg_wr, illegal;
   logic [1:0] ALUOp;
   logic [2:0] state;
   logic [13:0] act;

   multicycle_control #(.OPCODE_W(7), .ALUOP_W(2), .MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pc_wr(pc_wr), .ir_wr(ir_wr), .branch(branch), .mem_rd(mem_rd),
      .memtoReg(memtoReg), .mem_wr(mem_wr), .ALUSrc(ALUSrc), .reg_wr(reg_wr),
      .ALUOp(ALUOp), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   assign act = {state, pc_wr, ir_wr, branch, mem_rd, memtoReg, mem_wr, ALUSrc, reg_wr,
                 ALUOp, illegal};

   // control bits: {pc_wr, ir_wr, branch, mem_rd, memtoReg, mem_wr, ALUSrc, reg_wr}
   localparam logic [7:0] PC = 8'h80, IR = 8'h40, BR = 8'h20, MRD = 8'h10;
   localparam logic [7:0] M2R = 8'h08, MWR = 8'h04, ASRC = 8'h02, RW = 8'h01;

   logic [13:0] exp_q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;

   always @(negedge clk) begin
      logic [13:0] e;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (act !== e) begin
            bad++;
            $display("FAIL cycle%0d outputs: got st=%0d ctl=%b aluop=%b ill=%b, want st=%0d ctl=%b aluop=%b ill=%b",
                     cyc, act[13:11], act[10:3], act[2:1], act[0],
                     e[13:11], e[10:3], e[2:1], e[0]);
         end
      end
      total++;
      if (mem_rd === 1'b1 && mem_wr === 1'b1) begin
         bad++;
         $display("FAIL cycle%0d rd_wr_exclusive: got mem_rd=1 mem_wr=1, want not both", cyc);
      end
   end

   function automatic logic [13:0] ev(input logic [2:0] st, input logic [7:0] ctl,
                                      input logic [1:0] aop, input logic ill);
      return {st, ctl, aop, ill};
   endfunction

   // 0 R, 1 LOAD, 2 STORE, 3 BRANCH, 4 I-ALU, 5 JAL, 6 JALR, 7 LUI, -1 illegal
   function automatic int cls_of(input logic [6:0] op);
      case (op)
         7'b0110011: return 0;
         7'b0000011: return 1;
         7'b0100011: return 2;
         7'b1100011: return 3;
         7'b0010011: return 4;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
         7'b1101111: return 5;
         7'b1100111: return 6;
         7'b0110111: return 7;
`endif
         default:    return -1;
      endcase
   endfunction

   function automatic logic [6:0] rnd_op();
      return 7'($urandom);
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom);
   endfunction

   task automatic step(input logic r, input logic mr, input logic [6:0] op, input logic [13:0] e);
      @(posedge clk);
      #1;
      rst = r;
      mem_ready = mr;
      opcode = op;
      exp_q.push_back(e);
   endtask

   // FETCH or MEM access completing after w idle cycles; w >= MAXW times out.
   task automatic access(input logic [2:0] st, input logic [7:0] ctl, input int w,
                         output bit trapped);
      trapped = 1'b0;
      for (int k = 0; k < MAXW; k++) begin
         if (k == w) begin
            step(1'b0, 1'b1, rnd_op(), ev(st, ctl | ((st == 3'd0) ? (PC | IR) : 8'h00), 2'b00, 1'b0));
            return;
         end
         step(1'b0, 1'b0, rnd_op(), ev(st, ctl, 2'b00, 1'b0));
      end
      trapped = 1'b1;
   endtask

   // Sit in TRAP for n cycles, then one reset cycle (outputs forced low).
   task automatic trap_hold(input int n);
      repeat (n) step(1'b0, rnd_bit(), rnd_op(), ev(3'd7, 8'h00, 2'b00, 1'b1));
      step(1'b1, rnd_bit(), rnd_op(), ev(3'd7, 8'h00, 2'b00, 1'b0));
   endtask

   // rst_mem >= 0: assert reset after that many idle MEM cycles.
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input int rst_mem);
      bit tr;
      int c;
      logic [7:0] mctl;
      access(3'd0, MRD, fw, tr);
      if (tr) begin
         trap_hold(3);
         return;
      end
      c = cls_of(op);
      step(1'b0, rnd_bit(), op, ev(3'd1, 8'h00, 2'b00, 1'b0));
      if (c < 0) begin
         trap_hold(10);
         return;
      end
      case (c)
         0:       step(1'b0, rnd_bit(), rnd_op(), ev(3'd2, 8'h00, 2'b10, 1'b0));
         4:       step(1'b0, rnd_bit(), rnd_op(), ev(3'd2, ASRC, 2'b10, 1'b0));
         1, 2:    step(1'b0, rnd_bit(), rnd_op(), ev(3'd2, ASRC, 2'b00, 1'b0));
         3:       step(1'b0, rnd_bit(), rnd_op(), ev(3'd2, BR, 2'b01, 1'b0));
         5, 6:    step(1'b0, rnd_bit(), rnd_op(), ev(3'd2, PC | ASRC, 2'b00, 1'b0));
         default: step(1'b0, rnd_bit(), rnd_op(), ev(3'd2, ASRC, 2'b11, 1'b0));
      endcase
      if (c == 3) return;
      if (c == 1 || c == 2) begin
         mctl = (c == 1) ? MRD : MWR;
         if (rst_mem >= 0) begin
            repeat (rst_mem) step(1'b0, 1'b0, rnd_op(), ev(3'd3, mctl, 2'b00, 1'b0));
            step(1'b1, 1'b1, rnd_op(), ev(3'd3, 8'h00, 2'b00, 1'b0));
            return;
         end
         access(3'd3, mctl, mw, tr);
         if (tr) begin
            trap_hold(3);
            return;
         end
         if (c == 2) return;
      end
      step(1'b0, rnd_bit(), rnd_op(), ev(3'd4, RW | ((c == 1) ? M2R : 8'h00), 2'b00, 1'b0));
   endtask

   logic [6:0] ops [11] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111, 7'b0000000,
                            7'b0010011};

   initial begin
      int fw, mw, rm;
      logic [6:0] op;
      // reset cycle with mem_ready high: outputs stay forced low
      step(1'b1, 1'b1, 7'b0110011, ev(3'd0, 8'h00, 2'b00, 1'b0));
      run_instr(7'b0110011, 0, 0, -1);           // R, zero wait
      run_instr(7'b0000011, 0, 3, -1);           // LOAD, 3 wait cycles in MEM
      run_instr(7'b0100011, 0, 0, -1);           // STORE
      run_instr(7'b1100011, 0, 0, -1);           // BRANCH
      run_instr(7'b0010011, 2, 0, -1);           // I-ALU with fetch wait
      run_instr(7'b1111111, 0, 0, -1);           // illegal -> TRAP, reset
      run_instr(7'b0110011, MAXW, 0, -1);        // fetch timeout
      run_instr(7'b0110011, MAXW - 1, 0, -1);    // ready on last allowed cycle
      run_instr(7'b0100011, 0, 0, 1);            // reset mid-store
      run_instr(7'b0000011, 0, MAXW, -1);        // MEM timeout
      run_instr(7'b0000011, 0, MAXW - 1, -1);    // MEM ready on last allowed cycle
      run_instr(7'b1101111, 0, 0, -1);           // JAL
      run_instr(7'b0110111, 1, 0, -1);           // LUI
      for (int i = 0; i < 80; i++) begin
         op = ops[$urandom_range(0, 10)];
         if ($urandom_range(0, 9) == 0) op = rnd_op();
         fw = ($urandom_range(0, 11) == 0) ? MAXW : $urandom_range(0, 3);
         mw = ($urandom_range(0, 11) == 0) ? MAXW : $urandom_range(0, 3);
         rm = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : -1;
         run_instr(op, fw, mw, rm);
      end
      step(1'b0, 1'b0, 7'd0, ev(3'd0, MRD, 2'b00, 1'b0));
      @(posedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
